data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: ADDR_W, 8, word-index width; memory depth is 2**ADDR_W 32-bit words.
REQ-002 Parameter: WAIT_CYCLES, 2, wait states inserted between request acceptance and response (0..15).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: req_valid  input  1  CPU-side request present.
REQ-006 Port: req_ready  output  1  responder can accept a request this cycle.
REQ-007 Port: req_write  input  1  1 = store, 0 = load.
REQ-008 Port: req_addr  input  32  byte address.
REQ-009 Port: req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 Port: req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-011 Port: req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 Port: resp_valid  output  1  response present.
REQ-013 Port: resp_ready  input  1  CPU accepts response.
REQ-014 Port: resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 Port: resp_err  output  1  request was misaligned, illegal size, or out of range.

Function
REQ-016 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-017 Handshake: request accepted on a rising edge where req_valid=1 and req_ready=1; req_write, req_addr, req_size, req_unsigned, req_wdata SHALL be latched on that edge and ignored afterwards.
REQ-018 Acceptance edge: WAIT_CYCLES>0 -> WAIT with counter loaded WAIT_CYCLES-1; WAIT_CYCLES=0 -> RESP directly.
REQ-019 WAIT: counter decrements each edge; at counter=0, next edge -> RESP; resp_valid rises exactly WAIT_CYCLES+1 edges after the acceptance edge.
REQ-020 RESP: resp_valid, resp_rdata, resp_err held stable until an edge with resp_ready=1, which returns FSM to IDLE; no new request accepted on that same edge.
REQ-021 Error: resp_err=1 if req_size=11, halfword with addr[0]=1, word with addr[1:0]!=00, or addr[31:ADDR_W+2]!=0.
REQ-022 Stores SHALL commit to memory on the edge entering RESP, only when resp_err=0; only addressed byte lanes written (byte: lane addr[1:0]; half: lanes addr[1]*2..+1; word: all four).
REQ-023 Loads SHALL read word addr[ADDR_W+1:2] on the edge entering RESP, extract lane(s) as in REQ-022, extend per req_unsigned; word loads ignore req_unsigned.
REQ-024 Errored requests SHALL still complete the full WAIT/RESP sequence with resp_rdata=0, memory unchanged.
REQ-025 req_valid while not in IDLE SHALL have no effect; request stays pending until req_ready.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, counter 0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-027 Reset mid-transaction SHALL discard it; a store not yet committed (REQ-022) SHALL not modify memory.
REQ-028 Memory array contents SHALL not be affected by reset.

Verification
REQ-029 WAIT_CYCLES=2: store word 0xDEADBEEF to 0x10, then load word 0x10 -> resp_valid 3 edges after each acceptance, rdata=0xDEADBEEF, err=0.
REQ-030 Store byte 0x80 to 0x11 over 0xDEADBEEF; load byte 0x11 signed -> 0xFFFFFF80; unsigned -> 0x00000080; load word 0x10 -> 0xDEAD80EF.
REQ-031 Load half at 0x13, load word at 0x12, request size=11 -> each err=1, rdata=0, memory unchanged.
REQ-032 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata/err stable, req_ready=0, extra req_valid ignored; resp_ready=1 -> IDLE next edge.
REQ-033 Assert rst during WAIT of a store word 0x12345678 to 0x20 -> outputs reset immediately; later load 0x20 returns prior contents.
REQ-034 WAIT_CYCLES=0 build: accepted request -> resp_valid on the next edge; back-to-back requests with resp_ready tied 1 -> one completion every 2 cycles.

Source files
------------

// File: rtl/data_mem_responder.sv
// Single-ported data memory behind a valid/ready request/response handshake.
// Each request waits a fixed number of cycles, then holds its response until the CPU accepts it.
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, unsigned_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  logic              accept;
  logic              enter_resp;
  logic              cur_write, cur_unsigned, cur_err;
  logic [31:0]       cur_addr, cur_wdata;
  logic [1:0]        cur_size;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_word, rd_shift, load_val, wr_lanes;
  logic [3:0]        be;

  assign accept = req_valid && (state_q == S_IDLE);

  // With zero wait states the response is formed on the acceptance edge,
  // so the live request must be used before it has been latched.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_write    = req_write;
      cur_addr     = req_addr;
      cur_size     = req_size;
      cur_unsigned = req_unsigned;
      cur_wdata    = req_wdata;
    end else begin
      cur_write    = write_q;
      cur_addr     = addr_q;
      cur_size     = size_q;
      cur_unsigned = unsigned_q;
      cur_wdata    = wdata_q;
    end
  end

  always_comb begin
    cur_err = 1'b0;
    if (cur_size == 2'b11)                               cur_err = 1'b1;
    if (cur_size == SZ_HALF && cur_addr[0])              cur_err = 1'b1;
    if (cur_size == SZ_WORD && cur_addr[1:0] != 2'b00)   cur_err = 1'b1;
    if ((cur_addr >> (ADDR_W + 2)) != 32'd0)             cur_err = 1'b1;
  end

  assign idx      = cur_addr[ADDR_W+1:2];
  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {cur_addr[1:0], 3'b000};

  always_comb begin
    load_val = rd_word;
    be       = 4'b0000;
    wr_lanes = cur_wdata;
    case (cur_size)
      SZ_BYTE: begin
        load_val = cur_unsigned ? {24'd0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
        be       = 4'b0001 << cur_addr[1:0];
        wr_lanes = {4{cur_wdata[7:0]}};
      end
      SZ_HALF: begin
        load_val = cur_unsigned ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
        be       = 4'b0011 << {cur_addr[1], 1'b0};
        wr_lanes = {2{cur_wdata[15:0]}};
      end
      SZ_WORD: begin
        load_val = rd_word;
        be       = 4'b1111;
      end
      default: begin
        load_val = 32'd0;
        be       = 4'b0000;
      end
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      err_d   = cur_err;
      rdata_d = (cur_write || cur_err) ? 32'd0 : load_val;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= 32'd0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      wdata_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        write_q    <= req_write;
        addr_q     <= req_addr;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        wdata_q    <= req_wdata;
      end
    end
  end

  // NOTE: the memory array is deliberately not reset; its contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cur_write && !cur_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
